// File: rtl/float18_to_float32_cplx_pkg.sv
// Shared float constants and float-class encoding for the Float18 <-> float32 converters.
package float18_to_float32_cplx_pkg;

  localparam int F18_W        = 18;
  localparam int F32_BIAS     = 127;
  localparam int F32_EXP_W    = 8;
  localparam int F32_MAN_W    = 23;
  localparam int F32_QNAN_BIT = 22;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } float_class_t;

endpackage

// File: rtl/float18_to_float32_cplx_if.sv
// Complex Float18 in / complex float32 out stream bus.
// Handshake: a word moves when vld & rdy are both 1 on a rising clock edge; the sender
// holds vld and data steady until it moves, and rdy never depends on a future cycle.
interface float18_to_float32_cplx_if;
  import float18_to_float32_cplx_pkg::*;

  logic                 in_vld;
  logic                 in_rdy;
  logic [2*F18_W-1:0]   in_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [31:0]          out_re;
  logic [31:0]          out_im;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_re, out_im
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_re, out_im
  );

endinterface

// File: rtl/float18_to_float32_lane.sv
// One scalar Float18 -> float32 lane: stage 1 classifies and counts leading zeros,
// stage 2 packs the exact float32 result. Both stages advance only when en=1.
module float18_to_float32_lane
  import float18_to_float32_cplx_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [F18_W-1:0] f18,
  output logic [31:0]      f32
);

  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int PAD  = F32_MAN_W - MAN_W;
  localparam int LZ_W = $clog2(MAN_W + 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] m);
    lzc = LZ_W'(MAN_W);
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < MAN_W; i++) begin
      if (m[i]) lzc = LZ_W'(MAN_W - 1 - i);
    end
  endfunction

  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  float_class_t     in_cls;

  assign in_exp = f18[F18_W-2 -: EXP_W];
  assign in_man = f18[MAN_W-1:0];

  always_comb begin
    in_cls = NORM;
    if (in_exp == '0)      in_cls = (in_man == '0) ? ZERO : SUB;
    else if (in_exp == '1) in_cls = (in_man == '0) ? INF : NAN;
  end

  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;
  float_class_t     s1_cls;
  logic [LZ_W-1:0]  s1_lz;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_man  <= '0;
      s1_cls  <= ZERO;
      s1_lz   <= '0;
    end else if (en) begin
      s1_sign <= f18[F18_W-1];
      s1_exp  <= in_exp;
      s1_man  <= in_man;
      s1_cls  <= in_cls;
      s1_lz   <= lzc(in_man);
    end
  end

  logic [F32_MAN_W-1:0] man_pad;
  logic [MAN_W-1:0]     sub_man;
  logic [F32_EXP_W-1:0] norm_exp;
  logic [F32_EXP_W-1:0] sub_exp;
  logic [31:0]          f32_d;

  always_comb begin
    man_pad  = F32_MAN_W'(s1_man) << PAD;
    // Subnormal renormalisation drops the implicit leading one out the top.
    sub_man  = s1_man << (s1_lz + LZ_W'(1));
    norm_exp = F32_EXP_W'(s1_exp) + F32_EXP_W'(F32_BIAS - BIAS);
    sub_exp  = F32_EXP_W'(F32_BIAS - BIAS) - F32_EXP_W'(s1_lz);
    f32_d    = {s1_sign, norm_exp, man_pad};
    case (s1_cls)
      ZERO: f32_d = {s1_sign, 31'b0};
      SUB: begin
        if (EXP_W == F32_EXP_W) f32_d = {s1_sign, 8'h00, man_pad};
        else                    f32_d = {s1_sign, sub_exp, F32_MAN_W'(sub_man) << PAD};
      end
      INF: f32_d = {s1_sign, 8'hFF, 23'b0};
      NAN: begin
        f32_d               = {s1_sign, 8'hFF, man_pad};
        f32_d[F32_QNAN_BIT] = 1'b1;
      end
      default: f32_d = {s1_sign, norm_exp, man_pad};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     f32 <= '0;
    else if (en) f32 <= f32_d;
  end

endmodule

// File: rtl/float18_to_float32_cplx.sv
// Complex Float18 -> float32 widening converter: shared 2-stage valid pipeline,
// one independent datapath lane each for the real and imaginary parts.
module float18_to_float32_cplx
  import float18_to_float32_cplx_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 9
) (
  input logic                       clk,
  input logic                       rst,
  float18_to_float32_cplx_if.slave  bus
);

  logic en;
  logic s1_vld;
  logic s2_vld;

  // Whole pipeline moves together; it only freezes when the output word is refused.
  assign en          = ~s2_vld | bus.out_rdy;
  assign bus.in_rdy  = en & ~rst;
  assign bus.out_vld = s2_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (en) begin
      s1_vld <= bus.in_vld;
      s2_vld <= s1_vld;
    end
  end

  float18_to_float32_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_re (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .f18 (bus.in_data[2*F18_W-1 -: F18_W]),
    .f32 (bus.out_re)
  );

  float18_to_float32_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_im (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .f18 (bus.in_data[F18_W-1:0]),
    .f32 (bus.out_im)
  );

endmodule
